rv_lsu: RTL and testbench

// - Load/store unit: the initiator in front of rv_data_mem. Turns core LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses.
// - Memory is word-addressed, reads combinationally and writes a full 32-bit word only. SB/SH therefore use read-modify-write.
// - Sits between the core execute stage and rv_data_mem. Performs alignment, sign/zero extension and range checking.

---
 rtl/rv_lsu_pkg.sv | 17 +
 rtl/rv_lsu_align.sv | 39 +++
 rtl/rv_lsu.sv | 112 +++++++++++
 tb/tb_rv_lsu.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rv_lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states and the
// registered response bundle.
package rv_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} lsu_state_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        misalign;
    logic        fault;
  } resp_t;

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic: load extract/extend, store lane merge into a word,
// and alignment / illegal-size decode.
module rv_lsu_align
  import rv_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] rd_word,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word,
  output logic        misalign
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b       = rd_word[{lane, 3'b000} +: 8];
    h       = lane[1] ? rd_word[31:16] : rd_word[15:0];
    ld_data = rd_word;
    st_word = wdata;
    case (size)
      SZ_B: begin
        ld_data = {{24{~is_unsigned & b[7]}}, b};
        st_word = rd_word;
        st_word[{lane, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        ld_data = {{16{~is_unsigned & h[15]}}, h};
        st_word = lane[1] ? {wdata[15:0], rd_word[15:0]} : {rd_word[31:16], wdata[15:0]};
      end
      default: ;
    endcase
    misalign = (size == 2'b11) || (size == SZ_H && lane[0]) || (size == SZ_W && lane != 2'b00);
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit in front of a word-wide, combinationally read memory.
// Sub-word stores are done as read (ACCESS) then merged write (MERGE_WR).
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DMEM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_store_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [31:0]           resp_rdata_o,
  output logic                  resp_misalign_o,
  output logic                  resp_fault_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic                  dmem_wr_o,
  output logic [31:0]           dmem_wr_data_o,
  input  logic [31:0]           dmem_data_i
);

  lsu_state_t         state, state_n;
  logic [DMEM_AW+1:0] addr_q;
  logic [1:0]         size_q;
  logic               store_q, uns_q;
  logic [31:0]        wdata_q, merge_q;
  resp_t              resp_q;

  logic [1:0]  al_size, al_lane;
  logic        al_uns, mis, flt, accept, active;
  logic [31:0] al_rd, al_wd, ld_data, st_word;

  // In IDLE the aligner decodes the incoming request; afterwards the latched one.
  assign al_size = (state == IDLE) ? req_size_i       : size_q;
  assign al_lane = (state == IDLE) ? req_addr_i[1:0]  : addr_q[1:0];
  assign al_uns  = uns_q;
  assign al_wd   = wdata_q;
  assign al_rd   = (state == MERGE_WR) ? merge_q : dmem_data_i;

  rv_lsu_align u_align (
    .size        (al_size),
    .lane        (al_lane),
    .is_unsigned (al_uns),
    .rd_word     (al_rd),
    .wdata       (al_wd),
    .ld_data     (ld_data),
    .st_word     (st_word),
    .misalign    (mis)
  );

  assign flt    = |req_addr_i[ADDR_WIDTH-1:DMEM_AW+2];
  assign accept = (state == IDLE) && req_valid_i;
  assign active = !reset && (state == ACCESS || state == MERGE_WR);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_valid_i) state_n = (mis || flt) ? RESP : ACCESS;
      ACCESS:   state_n = (store_q && size_q != SZ_W) ? MERGE_WR : RESP;
      MERGE_WR: state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  assign req_ready_o     = (state == IDLE);
  assign resp_valid_o    = (state == RESP);
  assign resp_rdata_o    = resp_q.rdata;
  assign resp_misalign_o = resp_q.misalign;
  assign resp_fault_o    = resp_q.fault;
  assign dmem_addr_o     = active ? {{(ADDR_WIDTH-DMEM_AW){1'b0}}, addr_q[DMEM_AW+1:2]} : '0;
  assign dmem_wr_o       = !reset && ((state == ACCESS && store_q && size_q == SZ_W) || state == MERGE_WR);
  assign dmem_wr_data_o  = st_word;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      store_q <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      merge_q <= '0;
      resp_q  <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr_q  <= req_addr_i[DMEM_AW+1:0];
        size_q  <= req_size_i;
        store_q <= req_store_i;
        uns_q   <= req_unsigned_i;
        wdata_q <= req_wdata_i;
        if (mis || flt)
          resp_q <= '{rdata: 32'h0, misalign: mis, fault: !mis};
      end
      // Response fields only change on the way into RESP, so they hold between responses.
      if (state == ACCESS) begin
        if (!store_q)               resp_q  <= '{rdata: ld_data, misalign: 1'b0, fault: 1'b0};
        else if (size_q == SZ_W)    resp_q  <= '0;
        else                        merge_q <= dmem_data_i;
      end
      if (state == MERGE_WR) resp_q <= '0;
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Bench for rv_lsu with a behavioural word memory and a byte-mask reference model.
module tb_rv_lsu;
  import rv_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i, req_ready_o, req_store_i, req_unsigned_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_wdata_i;
  logic        resp_valid_o, resp_misalign_o, resp_fault_o;
  logic [31:0] resp_rdata_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_wr_o;
  logic [31:0] dmem_wr_data_o, dmem_data_i;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  int wr_cnt = 0;
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rv_lsu #(.ADDR_WIDTH(32), .DMEM_AW(10)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_store_i(req_store_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o),
    .resp_misalign_o(resp_misalign_o), .resp_fault_o(resp_fault_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wr_o(dmem_wr_o), .dmem_wr_data_o(dmem_wr_data_o),
    .dmem_data_i(dmem_data_i)
  );

  assign dmem_data_i = mem[dmem_addr_o[9:0]];

  always @(posedge clk)
    if (dmem_wr_o) begin
      mem[dmem_addr_o[9:0]] <= dmem_wr_data_o;
      wr_cnt <= wr_cnt + 1;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  // One request from a negedge; returns at the negedge after the response cycle.
  task automatic txn(input logic st, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd_obs);
    logic        mis_e, flt_e;
    logic [31:0] rd_e, w, v, mask;
    logic [9:0]  idx;
    int          lat_e, nwr_e, sh, sx, n, wr0;
    mis_e = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    flt_e = !mis_e && (a >= 32'h1000);
    idx   = 10'((a / 4) % 1024);
    w     = ref_mem[idx];
    sh    = int'(a % 4) * 8;
    rd_e  = 0; nwr_e = 0; lat_e = 1;
    if (!(mis_e || flt_e)) begin
      if (!st) begin
        lat_e = 2;
        v = w >> sh;
        if (sz == 2'd0) begin
          sx = int'(v & 32'hFF);
          if (!uns && sx >= 128) sx -= 256;
          rd_e = 32'(sx);
        end else if (sz == 2'd1) begin
          sx = int'(v & 32'hFFFF);
          if (!uns && sx >= 32768) sx -= 65536;
          rd_e = 32'(sx);
        end else rd_e = w;
      end else begin
        nwr_e = 1;
        lat_e = (sz == 2'd2) ? 2 : 3;
        mask  = ((sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF) << sh;
        ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
      end
    end
    check("ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1; req_store_i = st; req_size_i = sz; req_unsigned_i = uns;
    req_addr_i = a; req_wdata_i = wd;
    wr0 = wr_cnt;
    @(posedge clk); #1 req_valid_i = 0;
    n = 0;
    rd_obs = 'x;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1 && !(mis_e || flt_e)) check("dmem_addr", dmem_addr_o, 32'(idx));
      if (resp_valid_o) begin n = c; break; end
    end
    check("latency", 32'(n), 32'(lat_e));
    rd_obs = resp_rdata_o;
    check("rdata", resp_rdata_o, rd_e);
    check("misalign", 32'(resp_misalign_o), 32'(mis_e));
    check("fault", 32'(resp_fault_o), 32'(flt_e));
    @(negedge clk);
    check("writes", 32'(wr_cnt - wr0), 32'(nwr_e));
    check("mem_word", mem[idx], ref_mem[idx]);
    check("resp_hold", resp_rdata_o, rd_e);
    check("valid_pulse", 32'(resp_valid_o), 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int k;
    for (int i = 0; i < 1024; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    mem[1] = 32'h8899AABB; ref_mem[1] = 32'h8899AABB;
    reset = 1; req_valid_i = 0; req_store_i = 0; req_size_i = 0; req_unsigned_i = 0;
    req_addr_i = 0; req_wdata_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready_o), 32'd1);
    check("rst_valid", 32'(resp_valid_o), 32'd0);
    check("rst_rdata", resp_rdata_o, 32'd0);
    check("rst_flags", {30'd0, resp_misalign_o, resp_fault_o}, 32'd0);
    check("rst_dmem", {dmem_addr_o[30:0], dmem_wr_o}, 32'd0);
    reset = 0;

    txn(0, 2'd0, 0, 32'h6, 0, r); check("LB6", r, 32'hFFFFFF99);
    txn(0, 2'd0, 1, 32'h6, 0, r); check("LBU6", r, 32'h00000099);
    txn(0, 2'd1, 0, 32'h4, 0, r); check("LH4", r, 32'hFFFFAABB);
    txn(1, 2'd0, 0, 32'h5, 32'h12, r);
    txn(0, 2'd2, 0, 32'h4, 0, r); check("LW4_after_SB", r, 32'h889912BB);
    txn(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, r); check("SW8_mem", mem[2], 32'hDEADBEEF);
    txn(0, 2'd1, 0, 32'h3, 0, r);
    txn(0, 2'd2, 0, 32'h2, 0, r);
    txn(1, 2'd3, 0, 32'h0, 32'hFFFF, r);
    txn(1, 2'd2, 0, 32'h1000, 32'h12345678, r);

    // Reset lands in the MERGE_WR cycle of SH 0x4: the write must be suppressed.
    req_valid_i = 1; req_store_i = 1; req_size_i = 2'd1; req_unsigned_i = 0;
    req_addr_i = 32'h4; req_wdata_i = 32'h5555;
    @(posedge clk); #1 req_valid_i = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1; #1;
    check("rst_merge_wr", 32'(dmem_wr_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_merge_ready", 32'(req_ready_o), 32'd1);
    check("rst_merge_valid", 32'(resp_valid_o), 32'd0);
    check("rst_merge_mem", mem[1], 32'h889912BB);
    reset = 0;

    for (int i = 0; i < 80; i++) begin
      k = int'($urandom_range(0, 7));
      if (k == 0)      a = $urandom;
      else if (k == 1) a = 32'h1000 | 32'($urandom_range(0, 15));
      else             a = 32'($urandom_range(0, 63));
      txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          a, $urandom, r);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
